frame_filter: RTL
=================

FRAME_FILTER -- requirements
Module: frame_filter

Interface
REQ-001 Parameter DATA_WIDTH, default 512, AXIS data width in bits; DATA_WIDTH/8 keep and user bits.
REQ-002 Parameter ID_WIDTH, default 3, AXIS id width.
REQ-003 Parameter TEST_ETHERTYPE, default 16'h88B5, EtherType identifying testing frames.
REQ-004 Parameter TEST_MAGIC, default 32'h54414E4C, magic word following the EtherType in testing frames.
REQ-005 clk  in  1  single clock for all logic.
REQ-006 rst  in  1  reset, synchronous, active-high.
REQ-007 enable  in  1  1 = classify frames; 0 = route every frame to the bypass output.
REQ-008 clear  in  1  synchronously zero both frame counters.
REQ-009 test_count, other_count  out  32 each  completed frames sent to the test and bypass outputs.
REQ-010 axis_s_data/keep/last/user/id/valid  in, axis_s_ready out  DATA_WIDTH, DATA_WIDTH/8, 1, DATA_WIDTH/8, ID_WIDTH, 1, 1  input stream.
REQ-011 axis_t_data/keep/last/user/id/valid  out, axis_t_ready in  same widths  testing-frame output feeding the frame checker.
REQ-012 axis_b_data/keep/last/user/id/valid  out, axis_b_ready in  same widths  bypass output for all other frames.

Function
REQ-013 Byte n of a beat is data[8n+7:8n]; byte 0 of the first beat is the first byte of the frame.
REQ-014 A frame is a testing frame only if enable=1 when its first beat is accepted, keep[17:0] of the first beat is all ones, bytes 12..13 equal TEST_ETHERTYPE (byte 12 = MSB), and bytes 14..17 equal TEST_MAGIC (byte 14 = MSB).
REQ-015 Classification is made once, on the first beat; all later beats of the frame follow that route, regardless of enable or content changes.
REQ-016 State machine: HEAD (next accepted beat is a first beat), BODY (inside a frame, route latched); HEAD->BODY on accepting a beat with last=0; BODY->HEAD on accepting a beat with last=1; a single-beat frame stays in HEAD.
REQ-017 One-beat buffer: an accepted beat is stored with its route bit and presented on the selected output the next cycle; latency is exactly 1 cycle when the output is ready.
REQ-018 axis_s_ready = buffer empty, or buffer full and the selected output's ready is 1 in the same cycle (full throughput, one beat per cycle).
REQ-019 Only the selected output asserts valid; the unselected output's valid is 0; data/keep/last/user/id appear on both outputs unchanged.
REQ-020 A presented beat holds all fields and valid stable until the selected ready is 1 (AXIS rules); the non-selected ready is ignored.
REQ-021 test_count (other_count) increments by 1 when a beat with last=1 is transferred on the test (bypass) output; counters wrap modulo 2^32.
REQ-022 clear takes priority over a simultaneous increment: counter becomes 0.
REQ-023 Frames shorter than 18 valid bytes in the first beat, including single-beat runts, go to bypass.
REQ-024 tuser is passed through and never affects routing.

Reset
REQ-025 While rst=1 at a clk edge: state=HEAD, buffer empty, axis_s_ready=0, axis_t_valid=axis_b_valid=0, both counters 0.
REQ-026 First cycle after rst deasserts: axis_s_ready=1.
REQ-027 Reset mid-frame discards the buffered beat and latched route; the next accepted beat is treated as a first beat.

Verification
REQ-028 enable=1, 2-beat frame with bytes 12..17 = 88 B5 54 41 4E 4C, both readies 1 -> both beats on axis_t one cycle after acceptance, axis_b_valid=0 throughout, test_count=1.
REQ-029 Same frame with byte 13 = B6 -> frame on axis_b, other_count=1, test_count=0.
REQ-030 enable=1 at first beat, enable=0 before beat 2 of a 3-beat testing frame -> all 3 beats on axis_t; enable=0 at first beat -> whole frame on axis_b.
REQ-031 Back-to-back test/bypass/test single-beat frames, axis_t_ready=0 for 3 cycles -> first beat held stable on axis_t, axis_s_ready=0, no beat reordering, counts 2/1 after drain.
REQ-032 Single-beat frame with keep=16'hFFFF in low bits (16 bytes) and matching header pattern impossible -> routed to axis_b, other_count=1.
REQ-033 rst asserted during beat 2 of a 4-beat testing frame, then a 1-beat non-matching frame -> no outputs valid during reset, new frame on axis_b, counters 0 then other_count=1.

Source files
------------

// File: rtl/frame_filter.sv
// Splits an AXIS stream into testing frames (EtherType + magic on the first beat) and bypass frames.
// Latency: 1 cycle through a one-beat buffer; full throughput when the selected output is ready.
// Backpressure: input ready only while the buffer is empty or draining into the output it is routed to.
module frame_filter #(
    parameter int          DATA_WIDTH     = 512,
    parameter int          ID_WIDTH       = 3,
    parameter logic [15:0] TEST_ETHERTYPE = 16'h88B5,
    parameter logic [31:0] TEST_MAGIC     = 32'h54414E4C
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    enable,
    input  logic                    clear,
    output logic [31:0]             test_count,
    output logic [31:0]             other_count,

    input  logic [DATA_WIDTH-1:0]   axis_s_data,
    input  logic [DATA_WIDTH/8-1:0] axis_s_keep,
    input  logic                    axis_s_last,
    input  logic [DATA_WIDTH/8-1:0] axis_s_user,
    input  logic [ID_WIDTH-1:0]     axis_s_id,
    input  logic                    axis_s_valid,
    output logic                    axis_s_ready,

    output logic [DATA_WIDTH-1:0]   axis_t_data,
    output logic [DATA_WIDTH/8-1:0] axis_t_keep,
    output logic                    axis_t_last,
    output logic [DATA_WIDTH/8-1:0] axis_t_user,
    output logic [ID_WIDTH-1:0]     axis_t_id,
    output logic                    axis_t_valid,
    input  logic                    axis_t_ready,

    output logic [DATA_WIDTH-1:0]   axis_b_data,
    output logic [DATA_WIDTH/8-1:0] axis_b_keep,
    output logic                    axis_b_last,
    output logic [DATA_WIDTH/8-1:0] axis_b_user,
    output logic [ID_WIDTH-1:0]     axis_b_id,
    output logic                    axis_b_valid,
    input  logic                    axis_b_ready
);

    typedef enum logic {HEAD, BODY} state_t;

    state_t                  state, state_nxt;
    logic                    frame_route;
    logic                    route_in;
    logic                    head_match;
    logic                    accept;
    logic                    sel_rdy;
    logic                    out_xfer;

    logic                    buf_vld;
    logic                    buf_route;
    logic [DATA_WIDTH-1:0]   buf_data;
    logic [DATA_WIDTH/8-1:0] buf_keep;
    logic                    buf_last;
    logic [DATA_WIDTH/8-1:0] buf_user;
    logic [ID_WIDTH-1:0]     buf_id;

    // Header bytes are big-endian on the wire: byte 12 is the EtherType MSB.
    assign head_match = enable
                     && (&axis_s_keep[17:0])
                     && ({axis_s_data[103:96], axis_s_data[111:104]} == TEST_ETHERTYPE)
                     && ({axis_s_data[119:112], axis_s_data[127:120],
                          axis_s_data[135:128], axis_s_data[143:136]} == TEST_MAGIC);

    assign sel_rdy      = buf_route ? axis_t_ready : axis_b_ready;
    assign axis_s_ready = !rst && (!buf_vld || sel_rdy);
    assign accept       = axis_s_valid && axis_s_ready;
    assign out_xfer     = !rst && buf_vld && sel_rdy;

    always_comb begin
        state_nxt = state;
        route_in  = frame_route;
        if (state == HEAD) begin
            route_in = head_match;
        end
        if (accept) begin
            if (state == HEAD && !axis_s_last) begin
                state_nxt = BODY;
            end else if (state == BODY && axis_s_last) begin
                state_nxt = HEAD;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state       <= HEAD;
            frame_route <= 1'b0;
            buf_vld     <= 1'b0;
            buf_route   <= 1'b0;
        end else begin
            state <= state_nxt;
            if (accept && state == HEAD) begin
                frame_route <= route_in;
            end
            if (accept) begin
                buf_vld   <= 1'b1;
                buf_route <= route_in;
            end else if (out_xfer) begin
                buf_vld <= 1'b0;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (accept) begin
            buf_data <= axis_s_data;
            buf_keep <= axis_s_keep;
            buf_last <= axis_s_last;
            buf_user <= axis_s_user;
            buf_id   <= axis_s_id;
        end
    end

    // Clear wins over a same-cycle increment.
    always_ff @(posedge clk) begin
        if (rst || clear) begin
            test_count  <= 32'd0;
            other_count <= 32'd0;
        end else if (out_xfer && buf_last) begin
            if (buf_route) begin
                test_count <= test_count + 32'd1;
            end else begin
                other_count <= other_count + 32'd1;
            end
        end
    end

    assign axis_t_valid = !rst && buf_vld && buf_route;
    assign axis_b_valid = !rst && buf_vld && !buf_route;

    assign axis_t_data = buf_data;
    assign axis_t_keep = buf_keep;
    assign axis_t_last = buf_last;
    assign axis_t_user = buf_user;
    assign axis_t_id   = buf_id;

    assign axis_b_data = buf_data;
    assign axis_b_keep = buf_keep;
    assign axis_b_last = buf_last;
    assign axis_b_user = buf_user;
    assign axis_b_id   = buf_id;

endmodule
